// File: rtl/icache_if.sv
// Fetch-side and memory-arbiter-side signals of the instruction cache.
// slave = cache side, master = fetch unit / memory arbiter side.
interface icache_if;
  logic        flush;
  logic        asking;
  logic [31:0] addr;
  logic [31:0] data;
  logic        data_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_rdata;

  modport master (output flush, asking, addr, mem_valid, mem_rdata,
                  input  data, data_ready, mem_req, mem_addr);
  modport slave  (input  flush, asking, addr, mem_valid, mem_rdata,
                  output data, data_ready, mem_req, mem_addr);
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with byte-serial line refill and line-straddling fetches.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  icache_if.slave     bus
);
  localparam int LINE_BYTES = 1 << OFFSET_BITS;
  localparam int NLINES     = 1 << INDEX_BITS;
  localparam int LA         = INDEX_BITS + OFFSET_BITS;
  localparam int LW         = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_e;
  state_e state_q, state_d;

  logic [NLINES-1:0]          valid_q;
  logic [LW-INDEX_BITS-1:0]   tag_q   [NLINES];
  logic [7:0]                 bytes_q [NLINES*LINE_BYTES];

  logic [31:0]            addr_q, addr_d;
  logic                   pend_q, pend_d;
  logic [31:0]            pend_addr_q, pend_addr_d;
  logic [LW-1:0]          fill_q, fill_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   cancel_q, cancel_d;
  logic                   fill_we, line_done;

  logic [31:0]   req_addr;
  logic [LW-1:0] ra_line, rb_line, cb_line;
  logic          need_rb, need_cb, hit_ra, hit_rb, hit_cb;

  // A fetch needs the following line too when its 4 bytes run past the line end.
  assign req_addr = (pend_q ? pend_addr_q : bus.addr) & 32'hFFFF_FFFE;
  assign ra_line  = req_addr[31:OFFSET_BITS];
  assign rb_line  = ra_line + LW'(1);
  assign cb_line  = addr_q[31:OFFSET_BITS] + LW'(1);
  assign need_rb  = req_addr[OFFSET_BITS-1:0] > OFFSET_BITS'(LINE_BYTES-4);
  assign need_cb  = addr_q[OFFSET_BITS-1:0] > OFFSET_BITS'(LINE_BYTES-4);
  assign hit_ra   = valid_q[ra_line[INDEX_BITS-1:0]] &&
                    (tag_q[ra_line[INDEX_BITS-1:0]] == ra_line[LW-1:INDEX_BITS]);
  assign hit_rb   = valid_q[rb_line[INDEX_BITS-1:0]] &&
                    (tag_q[rb_line[INDEX_BITS-1:0]] == rb_line[LW-1:INDEX_BITS]);
  assign hit_cb   = valid_q[cb_line[INDEX_BITS-1:0]] &&
                    (tag_q[cb_line[INDEX_BITS-1:0]] == cb_line[LW-1:INDEX_BITS]);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    cancel_d    = cancel_q;
    fill_we     = 1'b0;
    line_done   = 1'b0;
    if (bus.asking && (state_q != IDLE || pend_q)) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.addr;
    end
    unique case (state_q)
      IDLE: if (pend_q || bus.asking) begin
        if (pend_q) pend_d = bus.asking;
        addr_d   = req_addr;
        cancel_d = 1'b0;
        if (hit_ra && (hit_rb || !need_rb)) begin
          state_d = RESP;
        end else begin
          state_d = REFILL;
          cnt_d   = '0;
          fill_d  = hit_ra ? rb_line : ra_line;
        end
      end
      REFILL: if (bus.mem_valid) begin
        fill_we = 1'b1;
        cnt_d   = cnt_q + OFFSET_BITS'(1);
        if (cnt_q == '1) begin
          line_done = 1'b1;
          if (cancel_q || bus.flush)                       state_d = IDLE;
          else if (fill_q != cb_line && need_cb && !hit_cb) fill_d  = cb_line;
          else                                             state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A refill already on the bus always runs to completion; only the response is cancelled.
    if (bus.flush) begin
      pend_d   = 1'b0;
      cancel_d = 1'b1;
      if (state_q != REFILL) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      cancel_q    <= cancel_d;
      if (line_done) valid_q[fill_q[INDEX_BITS-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   bytes_q[{fill_q[INDEX_BITS-1:0], cnt_q}] <= bus.mem_rdata;
    if (line_done) tag_q[fill_q[INDEX_BITS-1:0]] <= fill_q[LW-1:INDEX_BITS];
  end

  logic [31:0]   rdata;
  logic [LA-1:0] baddr;
  always_comb begin
    rdata = '0;
    baddr = '0;
    for (int k = 0; k < 4; k++) begin
      baddr = addr_q[LA-1:0] + LA'(k);
      rdata[8*k +: 8] = bytes_q[baddr];
    end
  end

  assign bus.data       = (state_q == RESP) ? rdata : '0;
  assign bus.data_ready = (state_q == RESP) && !bus.flush;
  assign bus.mem_req    = (state_q == REFILL);
  assign bus.mem_addr   = (state_q == REFILL) ? {fill_q, cnt_q} : '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (state_d == RESP)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_d == REFILL) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
